// File: rtl/demux_pkg.sv
// Shared sizing constants for the buffered 1:4 demultiplexer.
// These sizes do not change when DEMUX_COUNT_EN is set; the macro only adds the drain counters.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;

endpackage : demux_pkg

// File: rtl/demux_channel.sv
// One output channel of the demux: a one-entry holding register with a full flag.
// When DEMUX_COUNT_EN is defined, a wrapping counter of completed drains is added.
module demux_channel
    import demux_pkg::*;
#(
    parameter int bus_size = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [bus_size-1:0] wr_data,
    input  logic                rd_ready,
    output logic                rd_valid,
    output logic [bus_size-1:0] rd_data,
    output logic                free,
    output logic [CNT_W-1:0]    count
);

    logic                full_q;
    logic                full_d;
    logic [bus_size-1:0] data_q;
    logic [bus_size-1:0] data_d;
    logic                drain;

    // A write in the same cycle as a drain keeps the entry full with the new word.
    always_comb begin
        drain  = full_q & rd_ready;
        full_d = full_q;
        data_d = data_q;
        if (wr_en) begin
            full_d = 1'b1;
            data_d = wr_data;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign rd_valid = full_q;
    assign rd_data  = data_q;
    assign free     = ~full_q | rd_ready;

`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (drain) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
`else
    assign count = '0;
`endif

endmodule : demux_channel

// File: rtl/demux_1_4_buffered.sv
// Buffered 1:4 demux: one producer word is routed to one of four independent holding channels.
// Setting DEMUX_COUNT_EN enables the per-channel drain counters on out_count.
module demux_1_4_buffered
    import demux_pkg::*;
#(
    parameter int bus_size = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [bus_size-1:0]        in_data,
    input  logic [1:0]                 in_select,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [NUM_CH*bus_size-1:0] out_data,
    output logic [NUM_CH-1:0]          out_valid,
    input  logic [NUM_CH-1:0]          out_ready,
    output logic [NUM_CH*CNT_W-1:0]    out_count
);

    // Handshake rule on both sides: a word moves only in a cycle where valid and ready are both 1.
    // A held word's valid and data stay stable until it is taken. in_ready depends only on
    // the selected channel, never on in_valid, so a channel that is draining can accept again.
    logic [NUM_CH-1:0] free;
    logic [NUM_CH-1:0] wr_en;

    assign in_ready = free[in_select];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign wr_en[k] = in_valid & in_ready & (in_select == SEL_W'(k));

        demux_channel #(
            .bus_size(bus_size)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en[k]),
            .wr_data  (in_data),
            .rd_ready (out_ready[k]),
            .rd_valid (out_valid[k]),
            .rd_data  (out_data[k*bus_size +: bus_size]),
            .free     (free[k]),
            .count    (out_count[k*CNT_W +: CNT_W])
        );
    end

endmodule : demux_1_4_buffered

// File: tb/tb_demux_1_4_buffered.sv
// Bench for demux_1_4_buffered: vector table, hand-written corner sequences and random traffic.
// The reference model keeps, per channel, a flag, a word and a drain count.
module tb_demux_1_4_buffered;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  in_data;
    logic [1:0]   in_select;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [31:0]  out_count;

    int total = 0;
    int bad   = 0;

    logic        m_full[4];
    logic [31:0] m_data[4];
    int          m_cnt[4];
    logic        ir_seen;

    typedef struct {
        logic        v;
        logic [1:0]  s;
        logic [31:0] d;
        logic [3:0]  ord;
        logic        exp_ir;
        logic [3:0]  exp_valid;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[7];

    demux_1_4_buffered #(.bus_size(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_select (in_select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every output against the model; slices of empty channels are not compared.
    task automatic check_model();
        logic [3:0]   e_valid;
        logic [127:0] e_data;
        logic [127:0] mask;
        logic [31:0]  e_cnt;
        for (int k = 0; k < 4; k++) begin
            e_valid[k]          = m_full[k];
            e_data[k*32 +: 32]  = m_data[k];
            mask[k*32 +: 32]    = m_full[k] ? 32'hffff_ffff : 32'h0;
            e_cnt[k*8 +: 8]     = 8'(m_cnt[k] % 256);
        end
        check("out_valid", 128'(out_valid), 128'(e_valid));
        check("out_data", out_data & mask, e_data & mask);
        check("out_count", 128'(out_count), 128'(e_cnt));
    endtask

    // One clock: drive the inputs, check in_ready, then let the edge happen and check the outputs.
    task automatic step(input logic r, input logic v, input logic [1:0] s,
                        input logic [31:0] d, input logic [3:0] ord);
        logic exp_ir;
        rst_n = r; in_valid = v; in_select = s; in_data = d; out_ready = ord;
        #1;
        exp_ir  = !m_full[s] || ord[s];
        ir_seen = in_ready;
        check("in_ready", 128'(in_ready), 128'(exp_ir));
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (!r) begin
                m_full[k] = 1'b0;
                m_data[k] = '0;
                m_cnt[k]  = 0;
            end else begin
                logic drained;
                logic filled;
                drained = m_full[k] && ord[k];
                filled  = v && exp_ir && (s == 2'(k));
`ifdef DEMUX_COUNT_EN
                if (drained) m_cnt[k] = m_cnt[k] + 1;
`endif
                if (filled) begin
                    m_full[k] = 1'b1;
                    m_data[k] = d;
                end else if (drained) begin
                    m_full[k] = 1'b0;
                end
            end
        end
        check_model();
    endtask

    initial begin
        logic [31:0] exp_cnt;
        rst_n = 1'b0; in_valid = 1'b0; in_select = 2'd0; in_data = '0; out_ready = '0;
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 1'b0; m_data[k] = '0; m_cnt[k] = 0;
        end
        @(posedge clk);
        #1;

        // Reset held for two cycles while the producer is offering a word.
        step(1'b0, 1'b1, 2'd1, 32'hcafe_f00d, 4'b0000);
        step(1'b0, 1'b1, 2'd1, 32'hcafe_f00d, 4'b0000);
        check("reset out_valid", 128'(out_valid), 128'(4'b0000));
        check("reset out_data", out_data, 128'h0);
        check("reset out_count", 128'(out_count), 128'h0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        check("reset in_ready", 128'(in_ready), 128'(1'b1));

        // Table vectors, starting with every channel empty.
        vecs[0] = '{1'b1, 2'd2, 32'hdead_beef, 4'b0000, 1'b1, 4'b0100, 32'hdead_beef};
        vecs[1] = '{1'b0, 2'd2, 32'h0,         4'b0000, 1'b0, 4'b0100, 32'hdead_beef};
        vecs[2] = '{1'b1, 2'd1, 32'h0000_1111, 4'b0000, 1'b1, 4'b0110, 32'h0000_1111};
        vecs[3] = '{1'b1, 2'd1, 32'h0000_2222, 4'b0000, 1'b0, 4'b0110, 32'h0000_1111};
        vecs[4] = '{1'b1, 2'd3, 32'h0000_3333, 4'b0000, 1'b1, 4'b1110, 32'h0000_3333};
        vecs[5] = '{1'b1, 2'd0, 32'h0000_0044, 4'b0010, 1'b1, 4'b1101, 32'h0000_0044};
        vecs[6] = '{1'b0, 2'd1, 32'h0,         4'b1111, 1'b1, 4'b0000, 32'h0};
        for (int i = 0; i < 7; i++) begin
            step(1'b1, vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].ord);
            check("vec in_ready", 128'(ir_seen), 128'(vecs[i].exp_ir));
            check("vec out_valid", 128'(out_valid), 128'(vecs[i].exp_valid));
            if (vecs[i].exp_valid[vecs[i].s])
                check("vec word", 128'(out_data[vecs[i].s*32 +: 32]), 128'(vecs[i].exp_word));
        end

        // A word routed to channel 2 must stay stable while its consumer stalls.
        step(1'b1, 1'b1, 2'd2, 32'hdead_beef, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 2'd0, 32'h0, 4'b0000);
            check("hold slice2", 128'(out_data[95:64]), 128'(32'hdead_beef));
        end

        // With channel 1 full and stalled, a word for channel 1 is refused; channel 3 still accepts.
        step(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
        step(1'b1, 1'b1, 2'd1, 32'h0000_00a1, 4'b0000);
        step(1'b1, 1'b1, 2'd1, 32'h0000_00b1, 4'b0000);
        check("bp in_ready ch1", 128'(ir_seen), 128'(1'b0));
        check("bp slice1", 128'(out_data[63:32]), 128'(32'h0000_00a1));
        step(1'b1, 1'b1, 2'd3, 32'h0000_00c3, 4'b0000);
        check("bp out_valid", 128'(out_valid), 128'(4'b1010));

        // Drain and refill on channel 0, then stream 10 words in 10 cycles.
        step(1'b1, 1'b1, 2'd0, 32'h0000_0011, 4'b0000);
        step(1'b1, 1'b1, 2'd0, 32'h0000_0022, 4'b0001);
        check("refill in_ready", 128'(ir_seen), 128'(1'b1));
        check("refill valid0", 128'(out_valid[0]), 128'(1'b1));
        check("refill slice0", 128'(out_data[31:0]), 128'(32'h0000_0022));
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 2'd0, 32'h1000 + 32'(i), 4'b0001);
            check("stream in_ready", 128'(ir_seen), 128'(1'b1));
            check("stream slice0", 128'(out_data[31:0]), 128'(32'h1000 + 32'(i)));
        end

        // Reset while all four are full and every consumer is ready: no count from that cycle.
        step(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 2'(k), 32'h5000 + 32'(k), 4'b0000);
        check("all full", 128'(out_valid), 128'(4'b1111));
        step(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
        check("midreset out_valid", 128'(out_valid), 128'(4'b0000));
        check("midreset out_count", 128'(out_count), 128'h0);

        // 257 drains on channel 3.
        for (int i = 0; i < 257; i++) step(1'b1, 1'b1, 2'd3, $urandom, 4'b1000);
        step(1'b1, 1'b0, 2'd3, 32'h0, 4'b1000);
`ifdef DEMUX_COUNT_EN
        exp_cnt = 32'h0100_0000;
`else
        exp_cnt = 32'h0;
`endif
        check("count 257 drains", 128'(out_count), 128'(exp_cnt));

        // Random traffic, with an occasional reset.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 63) != 0), 1'($urandom), 2'($urandom_range(0, 3)),
                 $urandom, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_demux_1_4_buffered
